// File: rtl/div_unit_pkg.sv
// div_unit shared defines: bus widths, FSM state encodings
// and handshake constants for the iterative divider.
package div_unit_pkg;

    localparam int RegBus = 32;
    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic DivResultReady = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart = 1'b1;
    localparam logic DivStop = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// div_unit: 32-cycle radix-2 restoring divider for DIV/DIVU.
// Signed support compiled in only with macro DIV_UNIT_SIGNED_EN.
module div_unit
    import div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [RegBus-1:0] opdata1_i,
    input  logic [RegBus-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [63:0]       result_o,
    output logic              ready_o
);

    div_state_t state;
    logic [5:0] cnt;
    logic [RegBus-1:0] quo;
    logic [RegBus-1:0] rem;
    logic [RegBus-1:0] dvs;

    logic [RegBus:0] shifted;
    logic [RegBus+1:0] trial;
    logic [RegBus-1:0] mag1;
    logic [RegBus-1:0] mag2;
    logic [RegBus-1:0] q_fix;
    logic [RegBus-1:0] r_fix;
    logic [1:0] unused_bits;

    // Shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        shifted = {rem, quo[RegBus-1]};
        trial = {1'b0, shifted} - {2'b00, dvs};
    end

    // The shifted partial remainder never exceeds 33 bits' worth.
    assign unused_bits = {trial[RegBus], shifted[RegBus]};

`ifdef DIV_UNIT_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign mag1 = (signed_div_i && opdata1_i[RegBus-1])
                ? (~opdata1_i + 32'd1) : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[RegBus-1])
                ? (~opdata2_i + 32'd1) : opdata2_i;
    assign q_fix = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix = neg_r ? (~rem + 32'd1) : rem;

    // Remember which results need negating once iteration ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DivFree && start_i == DivStart
                     && !annul_i) begin
            neg_q <= signed_div_i
                   & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
            neg_r <= signed_div_i & opdata1_i[RegBus-1];
        end
    end
`else
    logic unused_sign;

    assign unused_sign = signed_div_i;
    assign mag1 = opdata1_i;
    assign mag2 = opdata2_i;
    assign q_fix = quo;
    assign r_fix = rem;
`endif

    // Control FSM with registered ready/result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DivFree;
            cnt <= 6'd0;
            quo <= ZeroWord;
            rem <= ZeroWord;
            dvs <= ZeroWord;
            ready_o <= DivResultNotReady;
            result_o <= {ZeroWord, ZeroWord};
        end else begin
            unique case (state)
                DivFree: begin
                    ready_o <= DivResultNotReady;
                    result_o <= {ZeroWord, ZeroWord};
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state <= DivOn;
                            cnt <= 6'd0;
                            quo <= mag1;
                            rem <= ZeroWord;
                            dvs <= mag2;
                        end
                    end
                end
                DivByZero: begin
                    state <= DivEnd;
                    ready_o <= DivResultReady;
                    result_o <= {ZeroWord, ZeroWord};
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else if (cnt == 6'd32) begin
                        state <= DivEnd;
                        ready_o <= DivResultReady;
                        result_o <= {r_fix, q_fix};
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (!trial[RegBus+1]) begin
                            rem <= trial[RegBus-1:0];
                            quo <= {quo[RegBus-2:0], 1'b1};
                        end else begin
                            rem <= shifted[RegBus-1:0];
                            quo <= {quo[RegBus-2:0], 1'b0};
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state <= DivFree;
                        ready_o <= DivResultNotReady;
                        result_o <= {ZeroWord, ZeroWord};
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule
